// File: rtl/csr_defs_pkg.sv
// Shared CSR definitions for the trap sequencer: addresses, bit indices, cause codes,
// mtvec modes, FSM states and the mstatus update helpers used on trap entry and MRET.
package csr_defs_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CAUSE_W = 4;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;

  localparam int unsigned MIE_MSIE = 3;
  localparam int unsigned MIE_MTIE = 7;
  localparam int unsigned MIE_MEIE = 11;

  localparam logic [CAUSE_W-1:0] CAUSE_MSI     = 4'd3;
  localparam logic [CAUSE_W-1:0] CAUSE_MTI     = 4'd7;
  localparam logic [CAUSE_W-1:0] CAUSE_MEI     = 4'd11;
  localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [CAUSE_W-1:0] CAUSE_EBREAK  = 4'd3;
  localparam logic [CAUSE_W-1:0] CAUSE_ECALL_M = 4'd11;

  localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTER,
    ST_REDIR,
    ST_RET
  } state_e;

  // Context captured at the commit boundary when a trap is taken
  typedef struct packed {
    logic                is_irq;
    logic [CAUSE_W-1:0]  cause;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     tval;
  } trap_ctx_t;

  function automatic logic [XLEN-1:0] enter_mstatus(input logic [XLEN-1:0] m);
    logic [XLEN-1:0] r;
    r                          = m;
    r[MSTATUS_MPIE]            = m[MSTATUS_MIE];
    r[MSTATUS_MIE]             = 1'b0;
    r[MSTATUS_MPP_LO +: 2]     = 2'b11;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] m);
    logic [XLEN-1:0] r;
    r                          = m;
    r[MSTATUS_MIE]             = m[MSTATUS_MPIE];
    r[MSTATUS_MPIE]            = 1'b1;
    r[MSTATUS_MPP_LO +: 2]     = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/csr_trap_ctrl_if.sv
// Core-side bundle of the trap sequencer: CSR inputs, interrupt lines, commit info,
// software CSR port, mstatus write-back and PC redirect.
interface csr_trap_ctrl_if;

  logic [csr_defs_pkg::XLEN-1:0]    mstatus_i;
  logic [csr_defs_pkg::XLEN-1:0]    mie_i;
  logic [csr_defs_pkg::XLEN-1:0]    mtvec_i;
  logic                             irq_ext;
  logic                             irq_tmr;
  logic                             irq_sw;
  logic                             instr_valid;
  logic [csr_defs_pkg::XLEN-1:0]    pc_i;
  logic                             exc_valid;
  logic [csr_defs_pkg::CAUSE_W-1:0] exc_cause;
  logic [csr_defs_pkg::XLEN-1:0]    exc_tval;
  logic                             mret_i;
  logic [11:0]                      csr_addr;
  logic                             csr_we;
  logic [csr_defs_pkg::XLEN-1:0]    csr_wdata;
  logic [csr_defs_pkg::XLEN-1:0]    csr_rdata;
  logic                             mstatus_we;
  logic [csr_defs_pkg::XLEN-1:0]    mstatus_wdata;
  logic                             stall;
  logic                             redirect_valid;
  logic [csr_defs_pkg::XLEN-1:0]    redirect_pc;

  modport slave (
    input  mstatus_i, mie_i, mtvec_i, irq_ext, irq_tmr, irq_sw,
    input  instr_valid, pc_i, exc_valid, exc_cause, exc_tval, mret_i,
    input  csr_addr, csr_we, csr_wdata,
    output csr_rdata, mstatus_we, mstatus_wdata, stall, redirect_valid, redirect_pc
  );

  modport master (
    output mstatus_i, mie_i, mtvec_i, irq_ext, irq_tmr, irq_sw,
    output instr_valid, pc_i, exc_valid, exc_cause, exc_tval, mret_i,
    output csr_addr, csr_we, csr_wdata,
    input  csr_rdata, mstatus_we, mstatus_wdata, stall, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/csr_irq_prio.sv
// Interrupt pending/priority encoder: MEI > MSI > MTI, gated by mstatus.MIE and mie.
module csr_irq_prio
  import csr_defs_pkg::*;
(
  input  logic               mstatus_mie,
  input  logic               mie_meie,
  input  logic               mie_msie,
  input  logic               mie_mtie,
  input  logic               irq_ext,
  input  logic               irq_sw,
  input  logic               irq_tmr,
  output logic               irq_pend,
  output logic [CAUSE_W-1:0] irq_cause
);

  logic ext_c;
  logic sw_c;
  logic tmr_c;

  assign ext_c    = mstatus_mie & mie_meie & irq_ext;
  assign sw_c     = mstatus_mie & mie_msie & irq_sw;
  assign tmr_c    = mstatus_mie & mie_mtie & irq_tmr;
  assign irq_pend = ext_c | sw_c | tmr_c;

  always_comb begin
    irq_cause = CAUSE_MTI;
    if (ext_c) begin
      irq_cause = CAUSE_MEI;
    end else if (sw_c) begin
      irq_cause = CAUSE_MSI;
    end
  end

endmodule

// File: rtl/csr_trap_ctrl.sv
// Trap sequencer: takes interrupts, exceptions and MRET at the commit boundary,
// owns mepc/mcause/mtval and redirects the PC.
module csr_trap_ctrl
  import csr_defs_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input logic            clk,
  input logic            rst,
  csr_trap_ctrl_if.slave bus
);

  state_e             state;
  trap_ctx_t          ctx;
  logic [XLEN-1:0]    mepc;
  logic [XLEN-1:0]    mcause;
  logic [XLEN-1:0]    mtval;
  logic               irq_pend;
  logic [CAUSE_W-1:0] irq_cause;
  logic [XLEN-1:0]    vec_base;
  logic [XLEN-1:0]    vec_target;
  logic               unused_mie;

  csr_irq_prio u_irq_prio (
    .mstatus_mie (bus.mstatus_i[MSTATUS_MIE]),
    .mie_meie    (bus.mie_i[MIE_MEIE]),
    .mie_msie    (bus.mie_i[MIE_MSIE]),
    .mie_mtie    (bus.mie_i[MIE_MTIE]),
    .irq_ext     (bus.irq_ext),
    .irq_sw      (bus.irq_sw),
    .irq_tmr     (bus.irq_tmr),
    .irq_pend    (irq_pend),
    .irq_cause   (irq_cause)
  );

  assign unused_mie = ^{bus.mie_i[31:12], bus.mie_i[10:8], bus.mie_i[6:4], bus.mie_i[2:0]};

  assign bus.stall = (state != ST_IDLE) ||
                     (bus.instr_valid && (irq_pend || bus.exc_valid || bus.mret_i));

  // A zero base means mtvec was never programmed; fall back to the boot vector
  assign vec_base   = {bus.mtvec_i[XLEN-1:2], 2'b00};
  assign vec_target = (vec_base == '0) ? RESET_PC :
                      vec_base + ((ctx.is_irq && (bus.mtvec_i[1:0] == MTVEC_VECTORED)) ?
                                  {26'b0, ctx.cause, 2'b00} : 32'h0);

  always_comb begin
    bus.csr_rdata = '0;
    case (bus.csr_addr)
      CSR_MEPC:   bus.csr_rdata = mepc;
      CSR_MCAUSE: bus.csr_rdata = mcause;
      CSR_MTVAL:  bus.csr_rdata = mtval;
      default:    bus.csr_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= ST_IDLE;
      ctx                <= '0;
      mepc               <= '0;
      mcause             <= '0;
      mtval              <= '0;
      bus.mstatus_we     <= 1'b0;
      bus.mstatus_wdata  <= '0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
    end else begin
      bus.mstatus_we     <= 1'b0;
      bus.redirect_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.csr_we) begin
            case (bus.csr_addr)
              CSR_MEPC:   mepc   <= {bus.csr_wdata[XLEN-1:2], 2'b00};
              CSR_MCAUSE: mcause <= bus.csr_wdata;
              CSR_MTVAL:  mtval  <= bus.csr_wdata;
              default:    ;
            endcase
          end
          if (bus.instr_valid && (irq_pend || bus.exc_valid)) begin
            ctx.is_irq        <= irq_pend;
            ctx.cause         <= irq_pend ? irq_cause : bus.exc_cause;
            ctx.pc            <= bus.pc_i;
            ctx.tval          <= bus.exc_tval;
            bus.mstatus_we    <= 1'b1;
            bus.mstatus_wdata <= enter_mstatus(bus.mstatus_i);
            state             <= ST_ENTER;
          end else if (bus.instr_valid && bus.mret_i) begin
            bus.mstatus_we     <= 1'b1;
            bus.mstatus_wdata  <= mret_mstatus(bus.mstatus_i);
            bus.redirect_valid <= 1'b1;
            bus.redirect_pc    <= mepc;
            state              <= ST_RET;
          end
        end
        // Trap CSR updates own this cycle; software writes are not accepted here
        ST_ENTER: begin
          mepc               <= {ctx.pc[XLEN-1:2], 2'b00};
          mcause             <= {ctx.is_irq, 27'b0, ctx.cause};
          mtval              <= ctx.is_irq ? '0 : ctx.tval;
          bus.redirect_valid <= 1'b1;
          bus.redirect_pc    <= vec_target;
          state              <= ST_REDIR;
        end
        ST_REDIR: state <= ST_IDLE;
        ST_RET:   state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule
